bf_r2_pipe: RTL and testbench
=============================

// Module: bf_r2_pipe
// PURPOSE
//  Pipelined, parametrised radix-2 DIT butterfly: oa = a + b*W, ob = a - b*W.
//  Generalises the combinational add/sub butterfly with:
//  - a twiddle multiply
//  - per-transaction divide-by-2 scaling
//  - saturation and a sticky overflow flag
//  - valid/ready flow control
//  Sits between the FFT stage memory reader and writer; one instance per FFT stage.
// PARAMETERS
//  DATA_W  16  width of each real/imag component of a, b, oa, ob (two's complement)
//  TW_W    16  width of each twiddle component, signed Q1.(TW_W-1)
//  PIPE_M  1   1: extra register after the multipliers (latency 4); 0: latency 3
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         input beat valid
//  in_ready   out  1         block can accept a beat this cycle
//  in_a       in   2*DATA_W  {imag,real} operand a
//  in_b       in   2*DATA_W  {imag,real} operand b
//  in_tw      in   2*TW_W    {imag,real} twiddle W
//  in_scale   in   1         1: outputs divided by 2 (rounded) for this beat
//  in_last    in   1         frame marker, passed through aligned with data
//  out_valid  out  1         output beat valid
//  out_ready  in   1         downstream accepts beat
//  out_a      out  2*DATA_W  {imag,real} a + b*W
//  out_b      out  2*DATA_W  {imag,real} a - b*W
//  out_last   out  1         in_last delayed with its beat
//  ovf        out  1         sticky: any saturation since reset/ovf_clr
//  ovf_clr    in   1         synchronous clear of ovf
// BEHAVIOUR
//  Reset:
//  - All valid bits, out_a, out_b, out_last and ovf are 0 while rst_n is low.
//  - in_ready is 1 after reset.
//  Flow control:
//  - en = !out_valid | out_ready; in_ready = en (combinational).
//  - A beat transfers when in_valid & in_ready.
//  - Every stage register and its valid bit advance only when en = 1.
//  - Stalls therefore hold the whole pipe.
//  - No beat is dropped or duplicated; the order of beats is preserved.
//  Latency: 3 cycles when PIPE_M = 0, 4 cycles when PIPE_M = 1 (accept to out_valid).
//  Throughput: 1 beat/clk when out_ready is held at 1.
//  Stage S1: register a, b, W, scale, last.
//  Stage S2: complex multiply p = b*W.
//  - Uses 4 signed products of DATA_W+TW_W bits.
//  - pr = br*wr - bi*wi and pi = br*wi + bi*wr, each DATA_W+TW_W+1 bits.
//  - Round half-up: add 2^(TW_W-2), then arithmetic shift right by TW_W-1.
//  - Result kept at DATA_W+2 bits, so W=-1, b=-2^(DATA_W-1) is exact.
//  Optional M stage: register after the S2 multipliers, present only when PIPE_M = 1.
//  Stage S3: s = a + p and d = a - p, each DATA_W+3 bits.
//  - If scale = 1: (x + 1) >>> 1.
//  - Then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  ovf flag:
//  - Set on the cycle any of the 4 output components saturates in a transferring beat.
//  - ovf_clr together with a new saturation in the same cycle leaves ovf = 1 (set wins).
//  Reset mid-operation: all in-flight beats are discarded; nothing is emitted after release.
//  out_* hold their values while out_valid & !out_ready.
// STRUCTURE
//  Package fft_pkg holds:
//  - typedef cplx_t {logic signed [DATA_W-1:0] re, im}
//  - typedef tw_t
//  - function sat(), function rnd_shr()
//  - constants for the rounding offsets
//  One sub-module, cplx_mul_rnd: S2 multiply and round, with an optional internal register.
//  The top holds the valid pipe, the add/sub/scale/saturate logic and the ovf flag.
// TESTING (DATA_W = TW_W = 16)
//  1. W=(32767,0), a=(100,-50), b=(20,30), scale=0
//     -> out_a=(120,-20), out_b=(80,-80) after the configured latency; ovf=0.
//  2. W=(0,-32768) (i.e. -j), b=(1000,0), a=0
//     -> out_a=(0,-1000), out_b=(0,1000).
//  3. a=(32767,0), b=(32767,0), W=(32767,0), scale=0
//     -> out_a.re=32767 (saturated), ovf=1.
//     Same beat with scale=1 -> out_a.re=32767 exact, no new ovf.
//  4. Stream 8 beats with out_ready toggled 1,0,0,1,...
//     -> same 8 results in order, none lost; in_ready=0 exactly when out_valid & !out_ready.
//  5. W=(-32768,0), b=(-32768,0), a=0
//     -> p=+32768, out_a.re saturates to 32767, out_b.re=-32768, ovf=1.
//     Then ovf_clr -> ovf=0.
//  6. Assert rst_n low with 3 beats in flight
//     -> out_valid=0 immediately; no stale beat after release; out_last tracks in_last.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and arithmetic helpers for the radix-2 FFT butterfly datapath.
// Latency: none; this package holds only types, constants and pure functions.
// Backpressure: not applicable.
//
// Contents:
//   DEF_DATA_W / DEF_TW_W  default component widths
//   cplx_t / tw_t          {im, re} packed complex sample and twiddle at default widths
//   CALC_W                 working width for the width-generic helpers below
//   rnd_ofs()              half-LSB offset for a given right shift
//   rnd_shr()              add rounding offset, then arithmetic shift right
//   sat()                  clamp to a signed range of a given width
package fft_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_TW_W   = 16;

  // Wide enough for any intermediate of the supported widths, so the helpers
  // can be width-generic; callers size-cast the result back down.
  localparam int CALC_W = 64;

  // The imaginary part sits in the upper half, matching the {imag,real} bus layout.
  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] im;
    logic signed [DEF_DATA_W-1:0] re;
  } cplx_t;

  typedef struct packed {
    logic signed [DEF_TW_W-1:0] im;
    logic signed [DEF_TW_W-1:0] re;
  } tw_t;

  // Rounding offset for the divide-by-2 output scaling.
  localparam logic signed [CALC_W-1:0] SCALE_RND_OFS = CALC_W'(1);

  // Half an output LSB for a right shift of sh bits (round half-up).
  function automatic logic signed [CALC_W-1:0] rnd_ofs(input int sh);
    logic signed [CALC_W-1:0] one;
    one = CALC_W'(1);
    if (sh > 0) return one <<< (sh - 1);
    return '0;
  endfunction

  function automatic logic signed [CALC_W-1:0] rnd_shr(
    input logic signed [CALC_W-1:0] x,
    input logic signed [CALC_W-1:0] ofs,
    input int                       sh
  );
    return (x + ofs) >>> sh;
  endfunction

  // Clamp x to [-2^(w-1), 2^(w-1)-1].
  function automatic logic signed [CALC_W-1:0] sat(
    input logic signed [CALC_W-1:0] x,
    input int                       w
  );
    logic signed [CALC_W-1:0] one, hi, lo;
    one = CALC_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/cplx_mul_rnd.sv
// Complex multiply p = b * W with round-half-up back to data scale.
// Latency: 1 cycle (PIPE_M = 0) or 2 cycles (PIPE_M = 1, products registered first).
// Backpressure: every register advances only when en is high; en low holds all state.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           pipeline advance enable
//   b            {imag,real} operand, DATA_W per component
//   w            {imag,real} twiddle, signed Q1.(TW_W-1)
//   p_re, p_im   rounded product, DATA_W+2 bits so that (-1)*(-2^(DATA_W-1)) is exact
module cplx_mul_rnd
  import fft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TW_W   = DEF_TW_W,
  parameter int PIPE_M = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [2*DATA_W-1:0]      b,
  input  logic [2*TW_W-1:0]        w,
  output logic signed [DATA_W+1:0] p_re,
  output logic signed [DATA_W+1:0] p_im
);

  localparam int MW = DATA_W + TW_W;  // single product
  localparam int SW = MW + 1;         // sum/difference of two products
  localparam int OW = DATA_W + 2;     // rounded result

  localparam logic signed [CALC_W-1:0] TW_RND_OFS = rnd_ofs(TW_W - 1);

  logic signed [DATA_W-1:0] br, bi;
  logic signed [TW_W-1:0]   wr, wi;

  assign br = b[DATA_W-1:0];
  assign bi = b[2*DATA_W-1:DATA_W];
  assign wr = w[TW_W-1:0];
  assign wi = w[2*TW_W-1:TW_W];

  logic signed [MW-1:0] rr, ii, ri, ir;
  logic signed [MW-1:0] rr_q, ii_q, ri_q, ir_q;

  assign rr = MW'(br) * MW'(wr);
  assign ii = MW'(bi) * MW'(wi);
  assign ri = MW'(br) * MW'(wi);
  assign ir = MW'(bi) * MW'(wr);

  generate
    if (PIPE_M != 0) begin : g_mreg
      // Breaks the multiplier-to-adder path for timing.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rr_q <= '0;
          ii_q <= '0;
          ri_q <= '0;
          ir_q <= '0;
        end else if (en) begin
          rr_q <= rr;
          ii_q <= ii;
          ri_q <= ri;
          ir_q <= ir;
        end
      end
    end else begin : g_nomreg
      assign rr_q = rr;
      assign ii_q = ii;
      assign ri_q = ri;
      assign ir_q = ir;
    end
  endgenerate

  logic signed [SW-1:0] pr, pi;

  assign pr = SW'(rr_q) - SW'(ii_q);
  assign pi = SW'(ri_q) + SW'(ir_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_re <= '0;
      p_im <= '0;
    end else if (en) begin
      p_re <= OW'(rnd_shr(CALC_W'(pr), TW_RND_OFS, TW_W - 1));
      p_im <= OW'(rnd_shr(CALC_W'(pi), TW_RND_OFS, TW_W - 1));
    end
  end

endmodule

// File: rtl/bf_r2_pipe.sv
// Pipelined radix-2 DIT butterfly: out_a = a + b*W, out_b = a - b*W, optional /2, saturating.
// Latency: 3 cycles (PIPE_M = 0) or 4 cycles (PIPE_M = 1) from accept to out_valid.
// Backpressure: en = !out_valid | out_ready stalls the whole pipe; in_ready = en.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake
//   in_a, in_b, in_tw      {imag,real} operands and twiddle
//   in_scale               divide this beat's outputs by 2 (rounded)
//   in_last                frame marker, travels with its beat
//   out_valid / out_ready  output handshake
//   out_a, out_b, out_last butterfly results and delayed frame marker
//   ovf, ovf_clr           sticky saturation flag and its synchronous clear
module bf_r2_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TW_W   = DEF_TW_W,
  parameter int PIPE_M = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_a,
  input  logic [2*DATA_W-1:0] in_b,
  input  logic [2*TW_W-1:0]   in_tw,
  input  logic                in_scale,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_a,
  output logic [2*DATA_W-1:0] out_b,
  output logic                out_last,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam int PW = DATA_W + 2;  // rounded product width
  localparam int EW = DATA_W + 3;  // a +/- p without overflow

  typedef struct packed {
    logic signed [DATA_W-1:0] im;
    logic signed [DATA_W-1:0] re;
  } cplx_w_t;

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // S1: input register
  logic                s1_vld, s1_scale, s1_last;
  cplx_w_t             s1_a;
  logic [2*DATA_W-1:0] s1_b;
  logic [2*TW_W-1:0]   s1_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_scale <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_w     <= '0;
    end else if (en) begin
      s1_vld   <= in_valid;
      s1_scale <= in_scale;
      s1_last  <= in_last;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_w     <= in_tw;
    end
  end

  // S2 (and optional M stage) for the product
  logic signed [PW-1:0] p_re, p_im;

  cplx_mul_rnd #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W),
    .PIPE_M (PIPE_M)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .b     (s1_b),
    .w     (s1_w),
    .p_re  (p_re),
    .p_im  (p_im)
  );

  // Side-band (a, scale, last, valid) delayed to match the multiplier depth.
  logic    m_vld, m_scale, m_last;
  cplx_w_t m_a;

  generate
    if (PIPE_M != 0) begin : g_mside
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m_vld   <= 1'b0;
          m_scale <= 1'b0;
          m_last  <= 1'b0;
          m_a     <= '0;
        end else if (en) begin
          m_vld   <= s1_vld;
          m_scale <= s1_scale;
          m_last  <= s1_last;
          m_a     <= s1_a;
        end
      end
    end else begin : g_nomside
      assign m_vld   = s1_vld;
      assign m_scale = s1_scale;
      assign m_last  = s1_last;
      assign m_a     = s1_a;
    end
  endgenerate

  logic    s2_vld, s2_scale, s2_last;
  cplx_w_t s2_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld   <= 1'b0;
      s2_scale <= 1'b0;
      s2_last  <= 1'b0;
      s2_a     <= '0;
    end else if (en) begin
      s2_vld   <= m_vld;
      s2_scale <= m_scale;
      s2_last  <= m_last;
      s2_a     <= m_a;
    end
  end

  // S3: add/sub, optional rounded /2, saturate
  logic signed [EW-1:0] sum_re, sum_im, dif_re, dif_im;

  assign sum_re = EW'($signed(s2_a.re)) + EW'(p_re);
  assign sum_im = EW'($signed(s2_a.im)) + EW'(p_im);
  assign dif_re = EW'($signed(s2_a.re)) - EW'(p_re);
  assign dif_im = EW'($signed(s2_a.im)) - EW'(p_im);

  // Component order 0..3: sum.re, sum.im, dif.re, dif.im
  logic signed [CALC_W-1:0] pre  [4];
  logic signed [CALC_W-1:0] scl  [4];
  logic signed [CALC_W-1:0] post [4];
  logic [3:0]               sat_hit;

  always_comb begin
    pre[0] = CALC_W'(sum_re);
    pre[1] = CALC_W'(sum_im);
    pre[2] = CALC_W'(dif_re);
    pre[3] = CALC_W'(dif_im);
    for (int i = 0; i < 4; i++) begin
      scl[i]     = s2_scale ? rnd_shr(pre[i], SCALE_RND_OFS, 1) : pre[i];
      post[i]    = sat(scl[i], DATA_W);
      sat_hit[i] = (post[i] != scl[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (en) begin
      out_valid <= s2_vld;
      out_last  <= s2_last;
      out_a     <= {post[1][DATA_W-1:0], post[0][DATA_W-1:0]};
      out_b     <= {post[3][DATA_W-1:0], post[2][DATA_W-1:0]};
    end
  end

  // Set takes priority over clear so a saturation coinciding with ovf_clr is not lost.
  logic ovf_set;

  assign ovf_set = en && s2_vld && (|sat_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else        ovf <= ovf_set || (ovf && !ovf_clr);
  end

endmodule

// File: tb/tb_bf_r2_pipe.sv
module tb_bf_r2_pipe;
  import fft_pkg::*;

  localparam int DW  = 16;
  localparam int TW  = 16;
  localparam int PM  = 1;
  localparam int LAT = (PM != 0) ? 4 : 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_scale, in_last;
  logic [2*DW-1:0] in_a, in_b, out_a, out_b;
  logic [2*TW-1:0] in_tw;
  logic          out_valid, out_ready, out_last, ovf, ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bf_r2_pipe #(.DATA_W(DW), .TW_W(TW), .PIPE_M(PM)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tw(in_tw),
    .in_scale(in_scale), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_last(out_last),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [31:0] oa;
    logic [31:0] ob;
    logic        last;
    bit          sat;
  } exp_t;

  function automatic logic [31:0] pk(input int re, input int im);
    cplx_t c;
    c.re = 16'(re);
    c.im = 16'(im);
    return c;
  endfunction

  // Reference: exact integer arithmetic, product rounded to nearest (ties up)
  // multiple of 2^15, optional rounded halving, clamp to 16-bit signed.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] w, input logic sc, input logic last);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    longint v [4];
    exp_t   e;
    ar = longint'($signed(a[15:0]));  ai = longint'($signed(a[31:16]));
    br = longint'($signed(b[15:0]));  bi = longint'($signed(b[31:16]));
    wr = longint'($signed(w[15:0]));  wi = longint'($signed(w[31:16]));
    pr = (br * wr - bi * wi + 16384) >>> 15;
    pi = (br * wi + bi * wr + 16384) >>> 15;
    v[0] = ar + pr;  v[1] = ai + pi;  v[2] = ar - pr;  v[3] = ai - pi;
    e.sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sc) v[i] = (v[i] + 1) >>> 1;
      if (v[i] > 32767) begin v[i] = 32767; e.sat = 1'b1; end
      else if (v[i] < -32768) begin v[i] = -32768; e.sat = 1'b1; end
    end
    e.oa   = {v[1][15:0], v[0][15:0]};
    e.ob   = {v[3][15:0], v[2][15:0]};
    e.last = last;
    return e;
  endfunction

  // Drives one beat into an idle pipe and captures the first output beat.
  task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                          input logic sc, input logic last, input logic clr,
                          output logic [31:0] oa, output logic [31:0] ob,
                          output logic olast, output logic oovf, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_tw = w; in_scale = sc; in_last = last;
    in_valid = 1'b1; out_ready = 1'b1; ovf_clr = clr;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin lat = k; break; end
    end
    oa = out_a; ob = out_b; olast = out_last; oovf = ovf;
    ovf_clr = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({out_valid, out_last, ovf, out_a, out_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b l=%0b ovf=%0b a=%h b=%h, want all zero",
               out_valid, out_last, ovf, out_a, out_b);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL after_reset: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] oa, ob; logic ol, ov; int lat;
    run_beat(pk(100, -50), pk(20, 30), pk(32767, 0), 1'b0, 1'b1, 1'b0, oa, ob, ol, ov, lat);
    n_tests++;
    if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    n_tests++;
    if (oa !== pk(120, -20) || ob !== pk(80, -80)) begin
      n_fail++; $display("FAIL basic_data: got a=%h b=%h want a=%h b=%h", oa, ob, pk(120, -20), pk(80, -80));
    end
    n_tests++;
    if (ov !== 1'b0 || ol !== 1'b1) begin
      n_fail++; $display("FAIL basic_flags: got ovf=%0b last=%0b want 0/1", ov, ol);
    end
  endtask

  task automatic test_neg_j();
    logic [31:0] oa, ob; logic ol, ov; int lat;
    run_beat(pk(0, 0), pk(1000, 0), pk(0, -32768), 1'b0, 1'b0, 1'b0, oa, ob, ol, ov, lat);
    n_tests++;
    if (oa !== pk(0, -1000) || ob !== pk(0, 1000) || ol !== 1'b0) begin
      n_fail++; $display("FAIL neg_j: got a=%h b=%h last=%0b want a=%h b=%h last=0",
                         oa, ob, ol, pk(0, -1000), pk(0, 1000));
    end
  endtask

  task automatic test_saturate();
    logic [31:0] oa, ob; logic ol, ov; int lat;
    run_beat(pk(32767, 0), pk(32767, 0), pk(32767, 0), 1'b0, 1'b0, 1'b0, oa, ob, ol, ov, lat);
    n_tests++;
    if (oa !== pk(32767, 0) || ob !== pk(1, 0) || ov !== 1'b1) begin
      n_fail++; $display("FAIL sat_noscale: got a=%h b=%h ovf=%0b want a=%h b=%h ovf=1",
                         oa, ob, ov, pk(32767, 0), pk(1, 0));
    end
    pulse_clr();
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear1: got %0b want 0", ovf); end
    run_beat(pk(32767, 0), pk(32767, 0), pk(32767, 0), 1'b1, 1'b0, 1'b0, oa, ob, ol, ov, lat);
    n_tests++;
    if (oa !== pk(32767, 0) || ob !== pk(1, 0) || ov !== 1'b0) begin
      n_fail++; $display("FAIL sat_scaled: got a=%h b=%h ovf=%0b want a=%h b=%h ovf=0",
                         oa, ob, ov, pk(32767, 0), pk(1, 0));
    end
    // ovf_clr held high while the saturating beat lands: the set must win.
    run_beat(pk(32767, 0), pk(32767, 0), pk(32767, 0), 1'b0, 1'b0, 1'b1, oa, ob, ol, ov, lat);
    n_tests++;
    if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %0b want 1", ov); end
  endtask

  task automatic test_corner_w();
    logic [31:0] oa, ob; logic ol, ov; int lat;
    pulse_clr();
    run_beat(pk(0, 0), pk(-32768, 0), pk(-32768, 0), 1'b0, 1'b1, 1'b0, oa, ob, ol, ov, lat);
    n_tests++;
    if (oa !== pk(32767, 0) || ob !== pk(-32768, 0) || ov !== 1'b1) begin
      n_fail++; $display("FAIL corner_w: got a=%h b=%h ovf=%0b want a=%h b=%h ovf=1",
                         oa, ob, ov, pk(32767, 0), pk(-32768, 0));
    end
    pulse_clr();
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear2: got %0b want 0", ovf); end
  endtask

  task automatic test_stream();
    exp_t q[$]; exp_t e;
    int   n = 40, sent = 0, got = 0, cyc = 0, bad = 0, bad_rdy = 0;
    bit   have = 0, any_sat = 0;
    pulse_clr();
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      if (!have && sent < n && $urandom_range(0, 3) != 0) begin
        in_a = $urandom; in_b = $urandom; in_tw = $urandom;
        if ($urandom_range(0, 1) == 0) in_b = {16'($urandom_range(0, 2000) - 1000), 16'($urandom_range(0, 2000) - 1000)};
        in_scale = 1'($urandom); in_last = 1'($urandom);
        have = 1;
      end
      in_valid  = have;
      out_ready = (cyc % 3 == 0);
      #1;
      if (in_ready !== !(out_valid && !out_ready)) bad_rdy++;
      if (in_valid && in_ready) begin
        e = model(in_a, in_b, in_tw, in_scale, in_last);
        any_sat |= e.sat;
        q.push_back(e);
        have = 0; sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          bad++; $display("FAIL stream_extra_beat: got a=%h with nothing outstanding", out_a);
        end else begin
          e = q.pop_front();
          if ({out_a, out_b, out_last} !== {e.oa, e.ob, e.last}) begin
            bad++;
            $display("FAIL stream_beat%0d: got a=%h b=%h l=%0b want a=%h b=%h l=%0b",
                     got, out_a, out_b, out_last, e.oa, e.ob, e.last);
          end
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL stream_data: got %0d bad beats want 0", bad); end
    n_tests++;
    if (got != n || q.size() != 0) begin
      n_fail++; $display("FAIL stream_count: got %0d out, %0d pending, want %0d/0", got, q.size(), n);
    end
    n_tests++;
    if (bad_rdy != 0) begin n_fail++; $display("FAIL stream_in_ready: got %0d bad cycles want 0", bad_rdy); end
    n_tests++;
    if (ovf !== logic'(any_sat)) begin n_fail++; $display("FAIL stream_ovf: got %0b want %0b", ovf, any_sat); end
  endtask

  task automatic test_back_to_back();
    exp_t q[$]; exp_t e;
    int   n = 16, sent = 0, got = 0, cyc = 0, bad = 0, first = -1, lastc = -1;
    out_ready = 1'b1;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      if (sent < n) begin
        in_a = $urandom; in_b = $urandom; in_tw = $urandom;
        in_scale = 1'($urandom); in_last = (sent == n - 1);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) begin q.push_back(model(in_a, in_b, in_tw, in_scale, in_last)); sent++; end
      if (out_valid) begin
        if (first < 0) first = cyc;
        lastc = cyc;
        if (q.size() == 0) bad++;
        else begin
          e = q.pop_front();
          if ({out_a, out_b, out_last} !== {e.oa, e.ob, e.last}) bad++;
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (bad != 0 || got != n) begin n_fail++; $display("FAIL b2b_data: got %0d bad, %0d beats want 0/%0d", bad, got, n); end
    n_tests++;
    if (first != LAT || lastc - first != n - 1) begin
      n_fail++; $display("FAIL b2b_timing: got first=%0d span=%0d want %0d/%0d", first, lastc - first, LAT, n - 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] oa, ob; logic ol, ov; int lat; int stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = pk(32767, 32767); in_b = pk(32767, 32767); in_tw = pk(32767, 0);
      in_scale = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, out_last, ovf, out_a, out_b} !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_outputs: got v=%0b l=%0b ovf=%0b a=%h rdy=%0b want 0/0/0/0/1",
                         out_valid, out_last, ovf, out_a, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    n_tests++;
    if (stale != 0) begin n_fail++; $display("FAIL midreset_stale: got %0d valid cycles want 0", stale); end
    run_beat(pk(100, -50), pk(20, 30), pk(32767, 0), 1'b0, 1'b1, 1'b0, oa, ob, ol, ov, lat);
    n_tests++;
    if (oa !== pk(120, -20) || ol !== 1'b1 || lat !== LAT) begin
      n_fail++; $display("FAIL midreset_resume: got a=%h last=%0b lat=%0d want a=%h last=1 lat=%0d",
                         oa, ol, lat, pk(120, -20), LAT);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_tw = '0;
    in_scale = 1'b0; in_last = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    test_reset();
    test_basic();
    test_neg_j();
    test_saturate();
    test_corner_w();
    test_stream();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
